// File: rtl/uart_reg_pkg.sv
// Shared constants for the UART register controller.
// Register addresses, LCR/LSR/IER bit positions, IIR codes, RX pop states.
package uart_reg_pkg;

  localparam logic [2:0] A_DATA  = 3'd0;
  localparam logic [2:0] A_IER   = 3'd1;
  localparam logic [2:0] A_IIR   = 3'd2;
  localparam logic [2:0] A_LCR   = 3'd3;
  localparam logic [2:0] A_BAUD0 = 3'd4;
  localparam logic [2:0] A_LSR   = 3'd5;
  localparam logic [2:0] A_BAUD1 = 3'd6;
  localparam logic [2:0] A_BAUD2 = 3'd7;

  localparam int LCR_ST  = 2;
  localparam int LCR_CHK = 3;
  localparam int LCR_PAR = 4;

  localparam int LSR_DR   = 0;
  localparam int LSR_PE   = 1;
  localparam int LSR_SE   = 2;
  localparam int LSR_OV   = 3;
  localparam int LSR_THRE = 5;
  localparam int LSR_IDLE = 6;

  localparam int IER_RX  = 0;
  localparam int IER_TX  = 1;
  localparam int IER_ERR = 2;

  localparam logic [7:0] IIR_ERR  = 8'h06;
  localparam logic [7:0] IIR_RX   = 8'h04;
  localparam logic [7:0] IIR_TX   = 8'h02;
  localparam logic [7:0] IIR_NONE = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POP,
    ST_WAIT
  } rx_state_e;

endpackage

// File: rtl/uart_reg_ctrl_err.sv
// Line-error latch: registered ack, rising-edge detect, sticky flag.
// Ports: clk, rstn, err (raw), clr (sticky clear), ack, sticky.
module uart_err_latch (
  input  logic clk,
  input  logic rstn,
  input  logic err,
  input  logic clr,
  output logic ack,
  output logic sticky
);

  // ack holds last cycle's err, so err & !ack is the rising edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack    <= 1'b0;
      sticky <= 1'b0;
    end else begin
      ack <= err;
      if (err && !ack)
        sticky <= 1'b1;
      else if (clr)
        sticky <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_reg_ctrl.sv
// Host register map and sequencing controller for UART_TOP.
// Ports: bus (addr/wr_en/rd_en/wdata/rdata/rvalid/busy/irq), UART config, FIFO and error side.
module uart_reg_ctrl
  import uart_reg_pkg::*;
#(
  parameter logic [19:0] DEF_BAUD  = 20'd115200,
  parameter logic [7:0]  DEF_LCR   = 8'h0F,
  parameter int          RX_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        rvalid,
  output logic        busy,
  output logic        irq,
  output logic [19:0] uart_buad,
  output logic [3:0]  data_length,
  output logic        check,
  output logic        st_check,
  output logic        parity,
  output logic [7:0]  tx_in_data,
  output logic        tx_fifo_write,
  output logic        rx_fifo_read,
  output logic        p_error_ack,
  output logic        st_error_ack,
  input  logic [7:0]  data_to_reg,
  input  logic [4:0]  rx_fifo_cnt,
  input  logic        rx_fifo_empty,
  input  logic        rx_work,
  input  logic [4:0]  tx_fifo_cnt,
  input  logic        tx_fifo_full,
  input  logic        tx_work,
  input  logic        p_error,
  input  logic        st_error
);

  localparam logic [7:0] LAT_LAST = 8'(RX_RD_LAT - 1);

  rx_state_e   state, state_nx;
  logic [7:0]  wait_cnt;
  logic        idle_st, wait_last;
  logic        wr_acc, rd_acc;
  logic        push, ovf_set, lsr_clr, pop_go;
  logic        cfg_idle;
  logic [2:0]  ier;
  logic [4:0]  lcr_sh, lcr_act;
  logic [19:0] baud_sh;
  logic        ovf, pe, se;
  logic [7:0]  lsr, iir, rd_val;
  logic        src_err, src_rx, src_tx;
  logic [7:0]  rdata_q;
  logic        rvalid_q;
  logic        tx_empty;

  assign tx_empty  = (tx_fifo_cnt == 5'd0);
  assign idle_st   = (state == ST_IDLE);
  assign wait_last = (state == ST_WAIT) &&
                     (wait_cnt == LAT_LAST);

  // write beats a simultaneous read
  assign wr_acc  = wr_en && idle_st;
  assign rd_acc  = rd_en && !wr_en && idle_st;
  assign push    = wr_acc && addr == A_DATA &&
                   !tx_fifo_full;
  assign ovf_set = wr_acc && addr == A_DATA &&
                   tx_fifo_full;
  assign lsr_clr = rd_acc && addr == A_LSR;
  assign pop_go  = rd_acc && addr == A_DATA &&
                   !rx_fifo_empty;

  // config may only change with the line fully quiet
  assign cfg_idle = !tx_work && !rx_work &&
                    tx_empty && !tx_fifo_write &&
                    !push;

  uart_err_latch u_perr (
    .clk    (clk),
    .rstn   (rstn),
    .err    (p_error),
    .clr    (lsr_clr),
    .ack    (p_error_ack),
    .sticky (pe)
  );

  uart_err_latch u_serr (
    .clk    (clk),
    .rstn   (rstn),
    .err    (st_error),
    .clr    (lsr_clr),
    .ack    (st_error_ack),
    .sticky (se)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state <= state_nx;
      if (state == ST_WAIT)
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= 8'd0;
    end
  end

  always_comb begin
    state_nx     = state;
    rx_fifo_read = 1'b0;
    busy         = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (pop_go)
          state_nx = ST_POP;
      end
      ST_POP: begin
        rx_fifo_read = 1'b1;
        state_nx     = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_last)
          state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ier     <= 3'd0;
      lcr_sh  <= DEF_LCR[4:0];
      baud_sh <= DEF_BAUD;
    end else if (wr_acc) begin
      case (addr)
        A_IER:   ier            <= wdata[2:0];
        A_LCR:   lcr_sh         <= wdata[4:0];
        A_BAUD0: baud_sh[7:0]   <= wdata;
        A_BAUD1: baud_sh[15:8]  <= wdata;
        A_BAUD2: baud_sh[19:16] <= wdata[3:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lcr_act   <= DEF_LCR[4:0];
      uart_buad <= DEF_BAUD;
    end else if (cfg_idle) begin
      lcr_act   <= lcr_sh;
      uart_buad <= baud_sh;
    end
  end

  assign data_length = {2'b00, lcr_act[1:0]} + 4'd5;
  assign st_check    = lcr_act[LCR_ST];
  assign check       = lcr_act[LCR_CHK];
  assign parity      = lcr_act[LCR_PAR];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_fifo_write <= 1'b0;
      tx_in_data    <= 8'd0;
      ovf           <= 1'b0;
    end else begin
      tx_fifo_write <= push;
      if (push)
        tx_in_data <= wdata;
      if (ovf_set)
        ovf <= 1'b1;
      else if (lsr_clr)
        ovf <= 1'b0;
    end
  end

  always_comb begin
    lsr           = 8'd0;
    lsr[LSR_DR]   = !rx_fifo_empty;
    lsr[LSR_PE]   = pe;
    lsr[LSR_SE]   = se;
    lsr[LSR_OV]   = ovf;
    lsr[LSR_THRE] = !tx_fifo_full;
    lsr[LSR_IDLE] = tx_empty && !tx_work;
  end

  // sources masked so the case items never overlap
  assign src_err = ier[IER_ERR] && |lsr[3:1];
  assign src_rx  = ier[IER_RX] && lsr[LSR_DR] &&
                   !src_err;
  assign src_tx  = ier[IER_TX] && tx_empty &&
                   !src_err && !src_rx;

  always_comb begin
    iir = IIR_NONE;
    unique case (1'b1)
      src_err: iir = IIR_ERR;
      src_rx:  iir = IIR_RX;
      src_tx:  iir = IIR_TX;
      default: iir = IIR_NONE;
    endcase
  end

  always_comb begin
    rd_val = 8'd0;
    case (addr)
      A_IER:   rd_val = {5'd0, ier};
      A_IIR:   rd_val = iir;
      A_LCR:   rd_val = {3'd0, lcr_sh};
      A_BAUD0: rd_val = baud_sh[7:0];
      A_LSR:   rd_val = lsr;
      A_BAUD1: rd_val = baud_sh[15:8];
      A_BAUD2: rd_val = {4'd0, baud_sh[19:16]};
      default: rd_val = 8'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q  <= 8'd0;
      rvalid_q <= 1'b0;
      irq      <= 1'b0;
    end else begin
      rvalid_q <= rd_acc && !pop_go;
      if (rd_acc && !pop_go)
        rdata_q <= rd_val;
      else if (wait_last)
        rdata_q <= data_to_reg;
      irq <= (ier[IER_RX] && lsr[LSR_DR]) ||
             (ier[IER_TX] && tx_empty) ||
             (ier[IER_ERR] && |lsr[3:1]);
    end
  end

  // popped byte is presented on the last WAIT cycle
  assign rdata  = wait_last ? data_to_reg : rdata_q;
  assign rvalid = rvalid_q || wait_last;

endmodule
